mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one scratchpad memory request port between NR requesters (port 0 = imem, port 1 = dmem, port 2 = HTIF when NR=3) using a round-robin grant.
- Tracks the requester ID of every in-flight access in an in-order tag FIFO, so each response is routed back to the requester that issued it.
- Sits between the core/HTIF memory ports and a single-port memory whose response arrives in order, 1 to DEPTH cycles after acceptance.

Parameters:
- NR, 3, number of requesters (2..8).
- DEPTH, 4, maximum outstanding requests; tag FIFO depth, power of two.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  [NR-1:0]  per-requester request valid.
- req_ready  out  [NR-1:0]  per-requester accept.
- req_addr  in  [NR-1:0][AW-1:0]  request address.
- req_data  in  [NR-1:0][DW-1:0]  store data.
- req_fcn  in  [NR-1:0]  0 = read, 1 = write.
- req_typ  in  [NR-1:0][2:0]  access size, MT_* encoding.
- resp_valid  out  [NR-1:0]  one-hot response strobe.
- resp_data  out  DW  response data, broadcast to all requesters.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory can accept.
- mem_req_addr / mem_req_data / mem_req_fcn / mem_req_typ  out  AW/DW/1/3  muxed request fields.
- mem_resp_valid  in  1  memory response, in order.
- mem_resp_data  in  DW  memory response data.
- outstanding  out  $clog2(DEPTH)+1  tag FIFO occupancy.
- err_orphan  out  1  sticky: response arrived with the FIFO empty.

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0. All valid/ready outputs are 0 while rst is high.
- issue_ok = mem_req_ready && (!full || mem_resp_valid). A pop in the same cycle frees a slot.
- Winner:
  - The first i with req_valid[i] set, scanning from rr_ptr upward and wrapping modulo NR.
  - Combinational; no request-to-grant latency.
- Handshake:
  - mem_req_valid = any(req_valid) && issue_ok.
  - req_ready[winner] = issue_ok. All other req_ready bits are 0.
  - mem_req_* fields = the winner's fields. They are don't-care when no request is valid.
- On accept (req_valid && req_ready):
  - Push the winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod NR.
  - rr_ptr does not change in cycles without an accept.
- Every accepted request, read or write, produces exactly one mem_resp_valid. Write responses carry don't-care data.
- On mem_resp_valid with the FIFO non-empty:
  - Pop the head ID h.
  - resp_valid = 1<<h in the same cycle, combinationally.
  - resp_data = mem_resp_data.
- On mem_resp_valid with the FIFO empty:
  - No resp_valid is asserted.
  - err_orphan <= 1 and stays set until reset.
- Simultaneous push and pop: occupancy is unchanged. When full, this case is legal and is the only way a request is accepted at full.
- Full FIFO with no pop: all req_ready bits are 0 and requests stall. Requesters hold their fields stable while valid.
- Pointer wrap: FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty detection uses an extra wrap bit.
- Fairness: any requester holding valid is granted within NR accepts.
- Reset mid-operation:
  - In-flight tags are discarded.
  - The memory must be reset in the same cycle. If it is not, any later late response sets err_orphan.
- The arbiter does not reorder, merge, or check address collisions.

Decomposition:
- Package mem_arb_pkg:
  - Constants M_XRD=1'b0, M_XWR=1'b1.
  - MT_B=3'd0, MT_H=3'd1, MT_W=3'd3, MT_BU=3'd4, MT_HU=3'd5.
  - typedef mem_req_t {addr, data, fcn, typ}.
  - typedef mem_resp_t {data}.
- One sub-module, arb_tag_fifo: a synchronous FIFO parameterized by DEPTH and width $clog2(NR), with push/pop/full/empty/count. It allows push when full if pop is asserted in the same cycle.
- The round-robin picker stays inline.

Test Plan:
- Single read: port 1 reads 0x100, memory returns 0xDEADBEEF the next cycle -> req_ready[1]=1 in the request cycle; one cycle later resp_valid=3'b010, resp_data=0xDEADBEEF; outstanding goes 0->1->0.
- Contention: ports 0,1,2 all hold valid for 6 cycles with memory always ready and 1-cycle latency -> grant order 0,1,2,0,1,2; responses strobe the matching one-hot bits in the same order.
- Full stall: DEPTH=4, memory withholds responses, port 0 issues 5 reads -> 4 accepted, 5th has req_ready=0 and outstanding=4. In the cycle the first response arrives, the 5th is accepted and outstanding stays 4.
- Backpressure: mem_req_ready=0 for 3 cycles with port 2 valid -> req_ready[2]=0, rr_ptr unchanged; accepted on the first ready cycle.
- Orphan: mem_resp_valid pulse with FIFO empty -> resp_valid=0, err_orphan=1 until rst.
- Async reset: assert rst mid-cycle with 2 outstanding -> outputs drop immediately; after release outstanding=0 and the next grant starts at port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and bundles for the scratchpad port arbiter.
// Memory command and access-size encodings.
package mem_arb_pkg;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;

  localparam int PKG_AW = 32;
  localparam int PKG_DW = 32;

  typedef struct packed {
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] data;
    logic              fcn;
    logic [2:0]        typ;
  } mem_req_t;

  typedef struct packed {
    logic [PKG_DW-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order requester-ID FIFO for outstanding memory accesses.
// Push at full is allowed when a pop frees the head slot in the same cycle.
module arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_q, wr_d;
  logic [PW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign count = wr_q - rd_q;
  assign dout  = mem_q[rd_q[PW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Tag storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NR requesters,
// routing in-order responses back through a tag FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NR    = 3,
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR-1:0]           req_valid,
  output logic [NR-1:0]           req_ready,
  input  logic [NR-1:0][AW-1:0]   req_addr,
  input  logic [NR-1:0][DW-1:0]   req_data,
  input  logic [NR-1:0]           req_fcn,
  input  logic [NR-1:0][2:0]      req_typ,
  output logic [NR-1:0]           resp_valid,
  output logic [DW-1:0]           resp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [AW-1:0]           mem_req_addr,
  output logic [DW-1:0]           mem_req_data,
  output logic                    mem_req_fcn,
  output logic [2:0]              mem_req_typ,
  input  logic                    mem_resp_valid,
  input  logic [DW-1:0]           mem_resp_data,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err_orphan
);

  localparam int IW = $clog2(NR);

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] win, head;
  logic          any, issue_ok, accept, pop;
  logic          full, empty;
  logic          orphan_q, orphan_d;

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (!any && req_valid[(int'(rr_q) + k) % NR]) begin
        any = 1'b1;
        win = IW'((int'(rr_q) + k) % NR);
      end
    end
  end

  // A same-cycle response frees a slot, so a full FIFO can still accept.
  assign issue_ok = mem_req_ready && (!full || mem_resp_valid);
  assign accept   = !rst && any && issue_ok;
  assign pop      = !rst && mem_resp_valid && !empty;

  assign mem_req_valid = accept;
  assign req_ready     = accept ? (NR'(1) << win) : '0;
  assign resp_valid    = pop ? (NR'(1) << head) : '0;
  assign resp_data     = mem_resp_data;

  assign mem_req_addr = req_addr[win];
  assign mem_req_data = req_data[win];
  assign mem_req_fcn  = req_fcn[win];
  assign mem_req_typ  = req_typ[win];

  always_comb begin
    rr_d     = rr_q;
    orphan_d = orphan_q;
    if (accept)
      rr_d = (win == IW'(NR - 1)) ? '0 : win + IW'(1);
    if (mem_resp_valid && empty)
      orphan_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      orphan_q <= orphan_d;
    end
  end

  assign err_orphan = orphan_q;

  arb_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (win),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

endmodule
